// File: rtl/arb_pkg.sv
// Shared types and default sizing for the RAM arbiter.
package arb_pkg;

    localparam int unsigned ADDR_W_DEF   = 16;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned MAX_WAIT_DEF = 4;
    localparam int unsigned LEN_W        = 8;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        FINISH
    } arb_state_t;

endpackage

// File: rtl/arb_burst_ctr.sv
// Burst address / remaining-beat counters with last-beat flag.
module arb_burst_ctr
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              advance,
    output logic [ADDR_W-1:0] burst_addr,
    output logic              last_beat
);

    logic [LEN_W-1:0] remaining;

    // Load on burst start; step address (wrapping) and count down on each beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_addr <= '0;
            remaining  <= '0;
        end else if (load) begin
            burst_addr <= load_addr;
            remaining  <= load_len;
        end else if (advance) begin
            burst_addr <= burst_addr + 1'b1;
            remaining  <= remaining - 1'b1;
        end
    end

    assign last_beat = (remaining == '0);

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a single-port RAM between the CPU memory stage and a burst master.
// The CPU has priority except when the burst master has been starved MAX_WAIT cycles.
module ram_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [LEN_W-1:0]  ext_len,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_beat,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    output logic              ext_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    arb_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              burst_we;
    logic              cpu_rv_q;
    logic              ext_rv_q;
    logic              done_q;

    logic              at_limit;
    logic              cpu_grant;
    logic              beat;
    logic              load;
    logic [ADDR_W-1:0] burst_addr;
    logic              last_beat;

    // Grant/beat decision; reset suppresses both so nothing reaches the RAM.
    always_comb begin
        at_limit  = (state == BURST) && (wait_cnt == WAIT_MAX);
        cpu_grant = cpu_req && !reset && !at_limit;
        beat      = (state == BURST) && !reset && (!cpu_req || at_limit);
        load      = (state == IDLE) && !reset && ext_req;
    end

    // RAM port mux driven from whichever requester won this cycle.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wren  = 1'b0;
        if (cpu_grant) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_wren  = cpu_we;
        end else if (beat) begin
            ram_addr  = burst_addr;
            ram_wdata = ext_wdata;
            ram_wren  = burst_we;
        end
    end

    // Burst FSM, starvation counter and read-valid tags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            burst_we <= 1'b0;
            cpu_rv_q <= 1'b0;
            ext_rv_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cpu_rv_q <= cpu_grant && !cpu_we;
            ext_rv_q <= beat && !burst_we;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (ext_req) begin
                        burst_we <= ext_we;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (beat) begin
                        wait_cnt <= '0;
                        if (last_beat) begin
                            state  <= FINISH;
                            done_q <= 1'b1;
                        end
                    end else if (cpu_grant) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    wait_cnt <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    arb_burst_ctr #(
        .ADDR_W (ADDR_W)
    ) u_burst_ctr (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_addr  (ext_addr),
        .load_len   (ext_len),
        .advance    (beat),
        .burst_addr (burst_addr),
        .last_beat  (last_beat)
    );

    // Registered flags are masked by reset so outputs read 0 from the first reset cycle.
    assign cpu_stall  = cpu_req && !cpu_grant;
    assign ext_beat   = beat;
    assign cpu_rvalid = cpu_rv_q && !reset;
    assign ext_rvalid = ext_rv_q && !reset;
    assign ext_done   = done_q && !reset;
    assign cpu_rdata  = reset ? '0 : ram_q;
    assign ext_rdata  = reset ? '0 : ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_stall;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_len;
    logic [7:0]  ext_wdata;
    logic        ext_beat;
    logic [7:0]  ext_rdata;
    logic        ext_rvalid;
    logic        ext_done;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_wren;
    logic [7:0]  ram_q;

    logic [7:0]  mem [0:65535];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (8),
        .MAX_WAIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_len    (ext_len),
        .ext_wdata  (ext_wdata),
        .ext_beat   (ext_beat),
        .ext_rdata  (ext_rdata),
        .ext_rvalid (ext_rvalid),
        .ext_done   (ext_done),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q)
    );

    // Single-port RAM, read data one cycle after address.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h5678;
        tick(); tick();
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rst_stall got=%b exp=1", cpu_stall); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got=%b exp=0", ram_wren); end
        checks++; if (ram_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got=%h exp=0000", ram_addr); end
        checks++; if (ext_beat !== 1'b0) begin errors++; $display("FAIL rst_beat got=%b exp=0", ext_beat); end
        checks++; if (ext_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", ext_done); end
        checks++; if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b%b exp=00", cpu_rvalid, ext_rvalid); end
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%h exp=00", cpu_rdata); end
        cpu_req = 1'b0; cpu_we = 1'b0; ext_req = 1'b0; ext_we = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_access();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_rd_stall got=%b exp=0", cpu_stall); end
        checks++; if (ram_addr !== 16'h0010) begin errors++; $display("FAIL cpu_rd_addr got=%h exp=0010", ram_addr); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL cpu_rd_wren got=%b exp=0", ram_wren); end
        tick();
        cpu_req = 1'b0;
        #1;
        checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL cpu_rvalid got=%b exp=1", cpu_rvalid); end
        checks++; if (cpu_rdata !== 8'h4A) begin errors++; $display("FAIL cpu_rdata got=%h exp=4a", cpu_rdata); end
        checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_rd_ext_rvalid got=%b exp=0", ext_rvalid); end
        // write: no rvalid afterwards
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'h77;
        #1;
        checks++; if (ram_wren !== 1'b1 || ram_wdata !== 8'h77) begin errors++; $display("FAIL cpu_wr got=%b/%h exp=1/77", ram_wren, ram_wdata); end
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_wr_rvalid got=%b exp=0", cpu_rvalid); end
        tick();
    endtask

    task automatic test_burst_write();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0100; ext_len = 8'd3; cpu_req = 1'b0;
        #1;
        checks++; if (ext_beat !== 1'b0) begin errors++; $display("FAIL bw_idle_beat got=%b exp=0", ext_beat); end
        tick();
        ext_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ext_wdata = 8'hC0 + 8'(i);
            #1;
            checks++; if (ext_beat !== 1'b1 || ram_wren !== 1'b1) begin errors++; $display("FAIL bw_beat%0d got=%b/%b exp=1/1", i, ext_beat, ram_wren); end
            checks++; if (ram_addr !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL bw_addr%0d got=%h exp=%h", i, ram_addr, 16'h0100 + 16'(i)); end
            checks++; if (ram_wdata !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL bw_data%0d got=%h exp=%h", i, ram_wdata, 8'hC0 + 8'(i)); end
            checks++; if (ext_done !== 1'b0) begin errors++; $display("FAIL bw_early_done%0d got=%b exp=0", i, ext_done); end
            tick();
        end
        #1;
        checks++; if (ext_done !== 1'b1 || ext_beat !== 1'b0) begin errors++; $display("FAIL bw_done got=%b/%b exp=1/0", ext_done, ext_beat); end
        checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL bw_rvalid got=%b exp=0", ext_rvalid); end
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0102;
        #1;
        checks++; if (ext_done !== 1'b0) begin errors++; $display("FAIL bw_done_len got=%b exp=0", ext_done); end
        tick();
        cpu_req = 1'b0;
        #1;
        checks++; if (cpu_rdata !== 8'hC2) begin errors++; $display("FAIL bw_readback got=%h exp=c2", cpu_rdata); end
        tick();
    endtask

    task automatic test_burst_read_wait();
        bit prev_beat = 1'b0;
        bit exp_beat;
        int nrv = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0200; ext_len = 8'd7;
        tick();
        ext_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            exp_beat = (c % 5 == 4);
            #1;
            checks++; if (ext_beat !== exp_beat) begin errors++; $display("FAIL br_beat c=%0d got=%b exp=%b", c, ext_beat, exp_beat); end
            checks++; if (cpu_stall !== exp_beat) begin errors++; $display("FAIL br_stall c=%0d got=%b exp=%b", c, cpu_stall, exp_beat); end
            checks++; if (ram_addr !== (exp_beat ? 16'h0200 + 16'(c / 5) : 16'h0010)) begin errors++; $display("FAIL br_addr c=%0d got=%h", c, ram_addr); end
            checks++; if (ext_rvalid !== prev_beat) begin errors++; $display("FAIL br_ext_rvalid c=%0d got=%b exp=%b", c, ext_rvalid, prev_beat); end
            checks++; if (cpu_rvalid !== !prev_beat) begin errors++; $display("FAIL br_cpu_rvalid c=%0d got=%b exp=%b", c, cpu_rvalid, !prev_beat); end
            if (ext_rvalid === 1'b1) begin
                checks++; if (ext_rdata !== (8'(nrv) ^ 8'h5A)) begin errors++; $display("FAIL br_rdata n=%0d got=%h exp=%h", nrv, ext_rdata, 8'(nrv) ^ 8'h5A); end
                nrv++;
            end
            tick();
            prev_beat = exp_beat;
        end
        #1;
        checks++; if (ext_done !== 1'b1 || ext_rvalid !== 1'b1) begin errors++; $display("FAIL br_done got=%b/%b exp=1/1", ext_done, ext_rvalid); end
        checks++; if (ext_rdata !== 8'h5D) begin errors++; $display("FAIL br_last_rdata got=%h exp=5d", ext_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL br_fin_stall got=%b exp=0", cpu_stall); end
        if (ext_rvalid === 1'b1) nrv++;
        checks++; if (nrv != 8) begin errors++; $display("FAIL br_rvalid_count got=%0d exp=8", nrv); end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        logic [15:0] exp_a [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'hFFFE; ext_len = 8'd2; cpu_req = 1'b0;
        tick();
        ext_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (ext_beat !== 1'b1 || ram_addr !== exp_a[k]) begin errors++; $display("FAIL wrap%0d got=%b/%h exp=1/%h", k, ext_beat, ram_addr, exp_a[k]); end
            tick();
        end
        #1;
        checks++; if (ext_done !== 1'b1 || ext_rvalid !== 1'b1) begin errors++; $display("FAIL wrap_done got=%b/%b exp=1/1", ext_done, ext_rvalid); end
        tick();
    endtask

    task automatic test_reset_mid();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0300; ext_len = 8'd5; cpu_req = 1'b0;
        tick();
        ext_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (ext_beat !== 1'b1 || ram_addr !== 16'h0300 + 16'(k)) begin errors++; $display("FAIL rm_beat%0d got=%b/%h", k, ext_beat, ram_addr); end
            tick();
        end
        reset = 1'b1;
        #1;
        checks++; if (ext_beat !== 1'b0 || ext_rvalid !== 1'b0 || ext_done !== 1'b0) begin errors++; $display("FAIL rm_in_reset got=%b%b%b exp=000", ext_beat, ext_rvalid, ext_done); end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (ext_beat !== 1'b0 || ext_rvalid !== 1'b0 || ext_done !== 1'b0) begin errors++; $display("FAIL rm_after%0d got=%b%b%b exp=000", k, ext_beat, ext_rvalid, ext_done); end
            tick();
        end
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0400; ext_len = 8'd0; ext_wdata = 8'h99;
        tick();
        ext_req = 1'b0;
        #1;
        checks++; if (ext_beat !== 1'b1 || ram_addr !== 16'h0400 || ram_wren !== 1'b1) begin errors++; $display("FAIL rm_new_beat got=%b/%h/%b exp=1/0400/1", ext_beat, ram_addr, ram_wren); end
        tick();
        #1;
        checks++; if (ext_done !== 1'b1 || ext_beat !== 1'b0) begin errors++; $display("FAIL rm_len0_done got=%b/%b exp=1/0", ext_done, ext_beat); end
        tick();
        #1;
        checks++; if (ext_done !== 1'b0 || ext_beat !== 1'b0) begin errors++; $display("FAIL rm_len0_idle got=%b/%b exp=0/0", ext_done, ext_beat); end
        tick();
    endtask

    task automatic test_req_held();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0500; ext_len = 8'd1; cpu_req = 1'b0;
        tick();
        ext_addr = 16'h0600;
        #1;
        checks++; if (ext_beat !== 1'b1 || ram_addr !== 16'h0500) begin errors++; $display("FAIL rh_b0 got=%b/%h exp=1/0500", ext_beat, ram_addr); end
        tick();
        #1;
        checks++; if (ext_beat !== 1'b1 || ram_addr !== 16'h0501) begin errors++; $display("FAIL rh_b1 got=%b/%h exp=1/0501", ext_beat, ram_addr); end
        tick();
        #1;
        checks++; if (ext_done !== 1'b1 || ext_beat !== 1'b0) begin errors++; $display("FAIL rh_finish got=%b/%b exp=1/0", ext_done, ext_beat); end
        tick();
        #1;
        checks++; if (ext_beat !== 1'b0 || ext_done !== 1'b0) begin errors++; $display("FAIL rh_idle got=%b/%b exp=0/0", ext_beat, ext_done); end
        tick();
        ext_req = 1'b0;
        #1;
        checks++; if (ext_beat !== 1'b1 || ram_addr !== 16'h0600) begin errors++; $display("FAIL rh_new got=%b/%h exp=1/0600", ext_beat, ram_addr); end
        tick();
        #1;
        checks++; if (ext_beat !== 1'b1 || ram_addr !== 16'h0601) begin errors++; $display("FAIL rh_new2 got=%b/%h exp=1/0601", ext_beat, ram_addr); end
        tick();
        #1;
        checks++; if (ext_done !== 1'b1) begin errors++; $display("FAIL rh_new_done got=%b exp=1", ext_done); end
        tick();
    endtask

    initial begin
        for (int unsigned i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_len = '0; ext_wdata = '0;
        @(negedge clk);
        test_reset();
        test_cpu_access();
        test_burst_write();
        test_burst_read_wait();
        test_wrap();
        test_reset_mid();
        test_req_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
